fd_instr_queue: RTL and testbench
=================================

Name: fd_instr_queue

Overview:
- Small instruction FIFO that sits directly downstream of the fetch unit and feeds the decode stage.
- Buffers fetched {PC, Instr} pairs so fetch continues while decode is stalled.
- Its full flag is the fetch PC write-enable throttle: PC_WrEn = ~F_Full.
- Decode pops one entry per cycle when it is ready; a flush (branch/jump redirect) discards all buffered entries.

Parameters:
- DEPTH, 4: number of entries; must be a power of two and at least 2.
- ADDR_W, 2: pointer width, log2(DEPTH).
- NOP_INSTR, 32'h0000_0000: value driven on D_Instr while the queue is empty.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- F_Valid  input  1  fetch presents a valid instruction this cycle.
- F_PC  input  32  PC of the presented instruction.
- F_Instr  input  32  presented instruction word.
- F_Full  output  1  queue full; fetch must hold its PC.
- D_Ready  input  1  decode accepts the head entry this cycle (not stalled).
- D_Valid  output  1  head entry valid.
- D_PC  output  32  PC of the head entry.
- D_Instr  output  32  instruction of the head entry.
- Flush  input  1  discard all entries (redirect).
- Count  output  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- State: storage mem_pc and mem_instr, each DEPTH x 32; wr_ptr and rd_ptr, each ADDR_W bits; cnt, ADDR_W+1 bits.
- Reset, synchronous: wr_ptr=0, rd_ptr=0, cnt=0. After the edge: D_Valid=0, D_PC=0, D_Instr=NOP_INSTR, F_Full=0, Count=0.
- Storage contents are not cleared by reset and are not observable while invalid.
- F_Full = (cnt == DEPTH). It is combinational from cnt only and has no path from D_Ready, so fetch sees no combinational loop.
- D_Valid = (cnt != 0).
- When D_Valid=1: D_PC = mem_pc[rd_ptr] and D_Instr = mem_instr[rd_ptr]. When D_Valid=0: D_PC = 0 and D_Instr = NOP_INSTR.
- push = F_Valid & ~F_Full & ~Flush. On push, the entry is written at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap).
- pop = D_Ready & D_Valid & ~Flush. On pop, rd_ptr increments modulo DEPTH.
- cnt update: push only, +1; pop only, -1; both or neither, unchanged.
- Latency: an entry pushed at edge N is visible at the head after edge N. There is no same-cycle bypass from F_* to D_*.
- Empty + F_Valid + D_Ready: the entry is pushed; nothing pops (D_Valid=0). Decode sees the entry in the following cycle.
- Full + F_Valid + D_Ready: pop only. The push is refused because F_Full=1 and is not retried internally; fetch still holds the PC, so it re-presents the same instruction the next cycle.
- Full + pop: F_Full drops in the following cycle.
- Flush (highest priority, beats push and pop): wr_ptr=0, rd_ptr=0, cnt=0 at the edge.
- Flush and the instruction presented in the same cycle: that instruction is dropped. The next cycle shows D_Valid=0 and F_Full=0.
- Delay-slot preservation is the redirect logic's responsibility: it asserts Flush only after the delay slot has been popped.
- Flush and reset together: identical result.
- Reset mid-operation: all entries are lost; outputs take their reset values after the edge.
- D_Ready while empty: no effect; rd_ptr does not move.
- Invariants:
  - cnt never exceeds DEPTH and never underflows.
  - (wr_ptr - rd_ptr) mod DEPTH == cnt mod DEPTH.

Test Plan:
1. Reset, then hold F_Valid=1, D_Ready=0 with F_PC=0x3000,0x3004,... for 5 cycles. Required: Count = 1,2,3,4,4; F_Full=1 after the 4th push; the entry with F_PC=0x3010 is refused. Head stays D_PC=0x3000, D_Instr=first word.
2. From full, set D_Ready=1 and F_Valid=0 for 4 cycles. Required: D_PC pops in order 0x3000, 0x3004, 0x3008, 0x300C; D_Valid=0 after the last pop; D_Instr=0.
3. Steady streaming, F_Valid=D_Ready=1, for 10 cycles starting from empty. Required: Count settles at 1. D_PC lags F_PC by exactly one cycle. The pointers wrap twice with no lost or duplicated PC.
4. Full queue, F_Valid=1, D_Ready=1. Required: one pop, no push, Count 4->3. Next cycle F_Full=0 and the held PC is accepted.
5. Queue holding 3 entries, Flush=1 with F_Valid=1 and D_Ready=1. Required: next cycle Count=0, D_Valid=0, F_Full=0. A following push of 0x4000 appears at the head one cycle later.
6. Queue holding 2 entries, reset asserted for 1 cycle together with F_Valid=1. Required: Count=0, D_Valid=0, D_PC=0 after the edge. The next push is read back correctly from index 0.

Source files
------------

// File: rtl/fd_instr_queue.sv
// Instruction queue between fetch and decode: buffers {PC, Instr} pairs so
// fetch keeps running while decode stalls; F_Full throttles the fetch PC.
module fd_instr_queue #(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              F_Valid,
    input  logic [31:0]       F_PC,
    input  logic [31:0]       F_Instr,
    output logic              F_Full,
    input  logic              D_Ready,
    output logic              D_Valid,
    output logic [31:0]       D_PC,
    output logic [31:0]       D_Instr,
    input  logic              Flush,
    output logic [ADDR_W:0]   Count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [DEPTH-1:0][31:0] mem_pc;
    logic [DEPTH-1:0][31:0] mem_instr;
    logic [ADDR_W-1:0]      wr_ptr;
    logic [ADDR_W-1:0]      rd_ptr;
    logic [ADDR_W:0]        cnt;
    logic                   push;
    logic                   pop;

    // Full depends on cnt alone, so there is no path from D_Ready to fetch.
    assign F_Full  = (cnt == FULL_CNT);
    assign D_Valid = (cnt != '0);
    assign Count   = cnt;

    assign push = F_Valid & ~F_Full & ~Flush;
    assign pop  = D_Ready & D_Valid & ~Flush;

    always_comb begin
        D_PC    = 32'h0;
        D_Instr = NOP_INSTR;
        if (D_Valid) begin
            D_PC    = mem_pc[rd_ptr];
            D_Instr = mem_instr[rd_ptr];
        end
    end

    // Storage carries no reset; stale contents are masked by D_Valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= F_PC;
            mem_instr[wr_ptr] <= F_Instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (ADDR_W+1)'(1);
                2'b01:   cnt <= cnt - (ADDR_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_fd_instr_queue.sv
// Directed bench for fd_instr_queue: fill/drain, streaming wrap, full
// back-pressure, flush and mid-run reset, all against hand-computed values.
module tb_fd_instr_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        F_Valid;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic        F_Full;
    logic        D_Ready;
    logic        D_Valid;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic        Flush;
    logic [2:0]  Count;

    int n_cmp = 0;
    int n_err = 0;

    fd_instr_queue #(.DEPTH(4), .ADDR_W(2), .NOP_INSTR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .F_Valid(F_Valid), .F_PC(F_PC), .F_Instr(F_Instr), .F_Full(F_Full),
        .D_Ready(D_Ready), .D_Valid(D_Valid), .D_PC(D_PC), .D_Instr(D_Instr),
        .Flush(Flush), .Count(Count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [31:0] pc, input logic rdy);
        F_Valid = v;
        F_PC    = pc;
        F_Instr = pc ^ 32'hA5A5_0000;
        D_Ready = rdy;
    endtask

    initial begin
        reset = 1'b1; Flush = 1'b0;
        present(1'b0, 32'h0, 1'b0);
        step();
        step();
        reset = 1'b0;
        chk("rst_valid", {31'h0, D_Valid}, 32'h0);
        chk("rst_pc",    D_PC, 32'h0);
        chk("rst_instr", D_Instr, 32'h0);
        chk("rst_full",  {31'h0, F_Full}, 32'h0);
        chk("rst_count", {29'h0, Count}, 32'h0);

        // 1: fill without decode; fifth push is refused
        for (int i = 0; i < 5; i++) begin
            present(1'b1, 32'h3000 + 32'(4*i), 1'b0);
            step();
            chk($sformatf("t1_count%0d", i), {29'h0, Count}, (i < 4) ? 32'(i+1) : 32'd4);
            chk($sformatf("t1_full%0d", i), {31'h0, F_Full}, (i >= 3) ? 32'd1 : 32'd0);
        end
        chk("t1_head_pc",    D_PC, 32'h3000);
        chk("t1_head_instr", D_Instr, 32'h3000 ^ 32'hA5A5_0000);

        // 2: drain in order
        present(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_pc%0d", i), D_PC, 32'h3000 + 32'(4*i));
            step();
        end
        chk("t2_valid", {31'h0, D_Valid}, 32'h0);
        chk("t2_instr", D_Instr, 32'h0);
        chk("t2_count", {29'h0, Count}, 32'h0);

        // 3: streaming from empty, head lags fetch by one cycle
        for (int i = 0; i < 10; i++) begin
            present(1'b1, 32'h5000 + 32'(4*i), 1'b1);
            step();
            chk($sformatf("t3_count%0d", i), {29'h0, Count}, 32'd1);
            chk($sformatf("t3_pc%0d", i), D_PC, 32'h5000 + 32'(4*i));
        end
        present(1'b0, 32'h0, 1'b1);
        step();
        chk("t3_empty", {31'h0, D_Valid}, 32'h0);

        // 4: full with push and pop: pop only, then held PC accepted
        for (int i = 0; i < 4; i++) begin
            present(1'b1, 32'h6000 + 32'(4*i), 1'b0);
            step();
        end
        chk("t4_full", {31'h0, F_Full}, 32'h1);
        present(1'b1, 32'h6010, 1'b1);
        step();
        chk("t4_count3", {29'h0, Count}, 32'd3);
        chk("t4_notfull", {31'h0, F_Full}, 32'h0);
        chk("t4_head", D_PC, 32'h6004);
        present(1'b1, 32'h6010, 1'b0);
        step();
        chk("t4_count4", {29'h0, Count}, 32'd4);
        present(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_pc%0d", i), D_PC, 32'h6004 + 32'(4*i));
            step();
        end
        chk("t4_empty", {29'h0, Count}, 32'd0);

        // 5: flush beats push and pop
        for (int i = 0; i < 3; i++) begin
            present(1'b1, 32'h7000 + 32'(4*i), 1'b0);
            step();
        end
        chk("t5_count3", {29'h0, Count}, 32'd3);
        present(1'b1, 32'h7100, 1'b1);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        chk("t5_count", {29'h0, Count}, 32'd0);
        chk("t5_valid", {31'h0, D_Valid}, 32'h0);
        chk("t5_full",  {31'h0, F_Full}, 32'h0);
        present(1'b1, 32'h4000, 1'b0);
        step();
        present(1'b0, 32'h0, 1'b0);
        chk("t5_head_pc", D_PC, 32'h4000);
        chk("t5_head_v",  {31'h0, D_Valid}, 32'h1);

        // 6: reset with two entries and a presented push
        present(1'b1, 32'h8000, 1'b0);
        step();
        chk("t6_count2", {29'h0, Count}, 32'd2);
        present(1'b1, 32'h8100, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_count", {29'h0, Count}, 32'd0);
        chk("t6_valid", {31'h0, D_Valid}, 32'h0);
        chk("t6_pc",    D_PC, 32'h0);
        present(1'b1, 32'h9000, 1'b0);
        step();
        present(1'b0, 32'h0, 1'b0);
        chk("t6_head_pc",    D_PC, 32'h9000);
        chk("t6_head_instr", D_Instr, 32'h9000 ^ 32'hA5A5_0000);
        chk("t6_count1",     {29'h0, Count}, 32'd1);

        // flush and reset together also empty the queue
        reset = 1'b1; Flush = 1'b1;
        step();
        reset = 1'b0; Flush = 1'b0;
        chk("t7_count", {29'h0, Count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
